// File: rtl/cpu_ad48_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ad48_mem_pkg
// Purpose  : Shared types and default widths for the cpu_ad48 memory path.
//            own_t records which requester owns the read response that the
//            memory returns one cycle after a read is issued.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ad48_mem_pkg;

   // Default word-address and data widths of the cpu_ad48 memories
   localparam int c_cpu_aw = 16;
   localparam int c_cpu_dw = 48;

   // Owner of the read response arriving in the next cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } own_t;

endpackage
`default_nettype wire

// File: rtl/cpu_ad48_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ad48_starve_ctr
// Purpose  : Saturating count of consecutive cycles the fetch port has been
//            refused. sat tells the arbiter that fetch must win next time.
// Ports    : clk   - clock
//            reset - synchronous active-high reset (clears the count)
//            inc   - count one more refused cycle (stops at STARVE_MAX)
//            clr   - restart from zero; overrides inc
//            sat   - count has reached STARVE_MAX
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ad48_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat
);

   localparam logic [3:0] c_max = 4'(STARVE_MAX);

   logic [3:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         r_cnt <= 4'd0;
      end else if (inc && (r_cnt != c_max)) begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   assign sat = (r_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/cpu_ad48_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ad48_mem_arb
// Purpose  : Shares one single-ported 48-bit word memory between instruction
//            fetch and load/store. One access per cycle; data wins unless
//            fetch has been refused STARVE_MAX cycles in a row. Read responses
//            (one cycle latency) are routed back by a registered owner tag;
//            a fetch response is dropped when if_flush is high.
// Ports    : clk, reset                       - clock, sync active-high reset
//            if_req/if_addr/if_flush          - fetch request and redirect
//            if_gnt/if_rvalid/if_rdata        - fetch grant and response
//            d_req/d_we/d_addr/d_wdata        - data request
//            d_gnt/d_rvalid/d_rdata           - data grant and response
//            mem_en/mem_we/mem_addr/mem_wdata - memory command
//            mem_rdata                        - memory read data (1 cycle)
// Revision : 1.0 - initial release
// ============================================================================
module cpu_ad48_mem_arb
   import cpu_ad48_mem_pkg::*;
#(
   parameter int AW         = c_cpu_aw,
   parameter int DW         = c_cpu_dw,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   own_t r_own;
   own_t w_own_nxt;
   logic w_sat;
   logic w_if_gnt;
   logic w_d_gnt;
   logic w_starve_inc;
   logic w_starve_clr;

   // Fetch wins only when data is idle or fetch has starved; a redirect
   // always kills the fetch grant, even at the starvation threshold.
   assign w_if_gnt = !reset && if_req && !if_flush && (!d_req || w_sat);
   assign w_d_gnt  = !reset && d_req && !w_if_gnt;

   assign w_starve_inc = if_req && !w_if_gnt && !if_flush;
   assign w_starve_clr = w_if_gnt || !if_req || if_flush;

   cpu_ad48_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk   (clk),
      .reset (reset),
      .inc   (w_starve_inc),
      .clr   (w_starve_clr),
      .sat   (w_sat)
   );

   // Owner of the response that mem_rdata will carry next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_own <= OWN_NONE;
      end else begin
         r_own <= w_own_nxt;
      end
   end

   always_comb begin
      w_own_nxt = OWN_NONE;
      if (w_if_gnt) begin
         w_own_nxt = OWN_IF;
      end else if (w_d_gnt && !d_we) begin
         w_own_nxt = OWN_D;
      end
   end

   // Memory command comes straight from the winner in the grant cycle
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_if_gnt) begin
         mem_en   = 1'b1;
         mem_addr = if_addr;
      end else if (w_d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   assign if_gnt = w_if_gnt;
   assign d_gnt  = w_d_gnt;

   // Reset also hides a response to a read granted just before reset rose
   assign if_rvalid = !reset && (r_own == OWN_IF) && !if_flush;
   assign d_rvalid  = !reset && (r_own == OWN_D);
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ad48_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_ad48_mem_arb
// Purpose  : Self-checking bench for cpu_ad48_mem_arb: directed scenarios
//            plus a randomized run against a behavioural reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_ad48_mem_arb;

   localparam int AW   = 16;
   localparam int DW   = 48;
   localparam int SMAX = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, if_flush, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_gnt, d_rvalid;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Memory as seen by the DUT, and the bench's own expected contents
   logic [DW-1:0] mem     [int];
   logic [DW-1:0] ref_mem [int];

   always #5 clk = ~clk;

   cpu_ad48_mem_arb #(
      .AW (AW), .DW (DW), .STARVE_MAX (SMAX)
   ) dut (
      .clk (clk), .reset (reset),
      .if_req (if_req), .if_addr (if_addr), .if_flush (if_flush),
      .if_gnt (if_gnt), .if_rvalid (if_rvalid), .if_rdata (if_rdata),
      .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
      .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
      .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr),
      .mem_wdata (mem_wdata), .mem_rdata (mem_rdata)
   );

   // Unwritten words hold an address-derived pattern
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      logic [15:0] m;
      m = a * 16'd7 + 16'd1;
      return {a, a ^ 16'hA5A5, m};
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
   endfunction

   // Single-port memory, one-cycle read latency; garbage when not reading
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mem[int'(mem_addr)] = mem_wdata;
      end
      if (mem_en && !mem_we) begin
         mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : init_val(mem_addr);
      end else begin
         mem_rdata <= {16'($urandom), 32'($urandom)};
      end
   end

   task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic fl,
                        input logic dr, input logic dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd);
      if_req = ir; if_addr = ia; if_flush = fl;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 16'd4, 48'h0);
         #2;
         n_checks++;
         if ({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_hold: gnt/en/rvalid=%b want 00000",
                     {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid});
         end
         @(negedge clk);
      end
      reset = 1'b0;
      drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      #2;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, mem_addr, mem_wdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_release_idle: ctl=%b addr=%h wdata=%h want all 0",
                  {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid}, mem_addr, mem_wdata);
      end
      @(negedge clk);
   endtask

   task automatic test_fetch_only();
      for (int k = 0; k < 4; k++) begin
         if (k < 3) drive(1'b1, 16'(k), 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
         else       drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
         #2;
         n_checks++;
         if ({if_gnt, d_gnt, mem_en, mem_we} !== ((k < 3) ? 4'b1010 : 4'b0000)) begin
            n_fail++;
            $display("FAIL fetch_grant[%0d]: gnt/en/we=%b", k, {if_gnt, d_gnt, mem_en, mem_we});
         end
         if (k < 3) begin
            n_checks++;
            if (mem_addr !== 16'(k)) begin
               n_fail++;
               $display("FAIL fetch_addr[%0d]: got %h want %h", k, mem_addr, 16'(k));
            end
         end
         n_checks++;
         if ({if_rvalid, d_rvalid} !== ((k > 0) ? 2'b10 : 2'b00)) begin
            n_fail++;
            $display("FAIL fetch_rvalid[%0d]: if/d=%b", k, {if_rvalid, d_rvalid});
         end
         if (k > 0) begin
            n_checks++;
            if (if_rdata !== init_val(16'(k - 1))) begin
               n_fail++;
               $display("FAIL fetch_rdata[%0d]: got %h want %h", k, if_rdata, init_val(16'(k - 1)));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_starvation();
      logic [AW-1:0] ia = 16'd200;
      logic [AW-1:0] da = 16'd100;
      logic [AW-1:0] pa = '0;
      bit p_if = 1'b0, p_d = 1'b0, eif, ed;
      for (int k = 0; k < 11; k++) begin
         if (k < 10) drive(1'b1, ia, 1'b0, 1'b1, 1'b0, da, 48'h0);
         else        drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
         #2;
         eif = (k < 10) && (k % 5 == 4);
         ed  = (k < 10) && !eif;
         n_checks++;
         if ({if_gnt, d_gnt} !== {eif, ed}) begin
            n_fail++;
            $display("FAIL starve_grant[%0d]: if/d=%b want %b", k, {if_gnt, d_gnt}, {eif, ed});
         end
         n_checks++;
         if ({if_rvalid, d_rvalid} !== {p_if, p_d}) begin
            n_fail++;
            $display("FAIL starve_rvalid[%0d]: if/d=%b want %b", k, {if_rvalid, d_rvalid}, {p_if, p_d});
         end
         if (p_if || p_d) begin
            n_checks++;
            if ((p_if ? if_rdata : d_rdata) !== init_val(pa)) begin
               n_fail++;
               $display("FAIL starve_rdata[%0d]: got %h want %h", k,
                        p_if ? if_rdata : d_rdata, init_val(pa));
            end
         end
         p_if = eif; p_d = ed; pa = eif ? ia : da;
         if (eif) ia++;
         if (ed)  da++;
         @(negedge clk);
      end
   endtask

   task automatic test_write_read();
      drive(1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 16'd5, 48'h123456789ABC);
      #2;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b0111, 16'd5, 48'h123456789ABC}) begin
         n_fail++;
         $display("FAIL wr_issue: ctl=%b addr=%h wdata=%h", {if_gnt, d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
      end
      @(negedge clk);
      drive(1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      #2;
      n_checks++;
      if ({if_gnt, mem_we, if_rvalid, d_rvalid} !== 4'b1000) begin
         n_fail++;
         $display("FAIL wr_then_fetch: gnt/we/rv=%b want 1000", {if_gnt, mem_we, if_rvalid, d_rvalid});
      end
      @(negedge clk);
      drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      #2;
      n_checks++;
      if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 48'h123456789ABC}) begin
         n_fail++;
         $display("FAIL wr_readback: rv=%b data=%h want 10 123456789abc", {if_rvalid, d_rvalid}, if_rdata);
      end
      @(negedge clk);
   endtask

   task automatic test_flush();
      drive(1'b1, 16'd7, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      #2;
      n_checks++;
      if (if_gnt !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_pre_grant: if_gnt=%b want 1", if_gnt);
      end
      @(negedge clk);
      drive(1'b1, 16'd8, 1'b1, 1'b1, 1'b0, 16'd9, 48'h0);
      #2;
      n_checks++;
      if ({if_gnt, d_gnt, if_rvalid, mem_addr} !== {3'b010, 16'd9}) begin
         n_fail++;
         $display("FAIL flush_cycle: if_gnt/d_gnt/if_rvalid=%b addr=%h want 010 0009",
                  {if_gnt, d_gnt, if_rvalid}, mem_addr);
      end
      @(negedge clk);
      drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      #2;
      n_checks++;
      if ({if_rvalid, d_rvalid, d_rdata} !== {2'b01, init_val(16'd9)}) begin
         n_fail++;
         $display("FAIL flush_data_resp: rv=%b data=%h want 01 %h", {if_rvalid, d_rvalid}, d_rdata, init_val(16'd9));
      end
      @(negedge clk);
   endtask

   task automatic test_flush_vs_starve();
      bit eif;
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 16'd40, (k == 4), 1'b1, 1'b0, 16'(50 + k), 48'h0);
         #2;
         eif = (k == 9);
         n_checks++;
         if ({if_gnt, d_gnt} !== {eif, !eif}) begin
            n_fail++;
            $display("FAIL flush_starve_grant[%0d]: if/d=%b want %b", k, {if_gnt, d_gnt}, {eif, !eif});
         end
         @(negedge clk);
      end
      drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 16'd30, 1'b0, 1'b1, 1'b0, (k == 3) ? 16'd11 : 16'(20 + k), 48'h0);
         #2;
         n_checks++;
         if ({if_gnt, d_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstmid_pre[%0d]: if/d=%b want 01", k, {if_gnt, d_gnt});
         end
         @(negedge clk);
      end
      reset = 1'b1;
      drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      #2;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid} !== 5'b0) begin
         n_fail++;
         $display("FAIL rstmid_drop: gnt/en/rv=%b want 00000", {if_gnt, d_gnt, mem_en, if_rvalid, d_rvalid});
      end
      @(negedge clk);
      drive(1'b1, 16'd31, 1'b0, 1'b1, 1'b0, 16'd60, 48'h0);
      #2;
      n_checks++;
      if ({if_gnt, d_gnt, mem_en} !== 3'b0) begin
         n_fail++;
         $display("FAIL rstmid_req_in_reset: gnt/en=%b want 000", {if_gnt, d_gnt, mem_en});
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 16'd31, 1'b0, 1'b1, 1'b0, 16'(60 + k), 48'h0);
         #2;
         n_checks++;
         if ({if_gnt, d_gnt} !== ((k == 4) ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL rstmid_restart[%0d]: if/d=%b", k, {if_gnt, d_gnt});
         end
         @(negedge clk);
      end
      drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      @(negedge clk);
   endtask

   // Reference: data has priority unless fetch has waited SMAX cycles;
   // a flush refuses fetch and restarts its wait; reads answer next cycle.
   task automatic test_random();
      int            waited = 0;
      bit            pend_if = 1'b0, pend_d = 1'b0;
      logic [DW-1:0] pend_data = '0;
      bit            ir = 1'b0, dr = 1'b0, dw = 1'b0, fl = 1'b0;
      bit            ir_hold = 1'b0, dr_hold = 1'b0, eif, ed;
      logic [AW-1:0] ia = '0, da = '0, ea;
      logic [DW-1:0] dd = '0, ewd;
      for (int k = 0; k < 400; k++) begin
         if (!ir_hold) begin
            ir = ($urandom % 4) != 0;
            ia = 16'($urandom_range(64, 127));
         end
         if (!dr_hold) begin
            dr = ($urandom % 3) != 0;
            dw = ($urandom % 3) == 0;
            da = 16'($urandom_range(64, 127));
            dd = {16'($urandom), 32'($urandom)};
         end
         fl = ($urandom % 8) == 0;
         drive(ir, ia, fl, dr, dw, da, dd);
         #2;
         eif = ir && !fl && (!dr || waited == SMAX);
         ed  = dr && !eif;
         ea  = eif ? ia : (ed ? da : '0);
         ewd = ed ? dd : '0;
         n_checks++;
         if ({if_gnt, d_gnt, mem_en, mem_we} !== {eif, ed, eif || ed, ed && dw}) begin
            n_fail++;
            $display("FAIL rand_grant[%0d]: if/d/en/we=%b want %b", k,
                     {if_gnt, d_gnt, mem_en, mem_we}, {eif, ed, eif || ed, ed && dw});
         end
         n_checks++;
         if ({mem_addr, mem_wdata} !== {ea, ewd}) begin
            n_fail++;
            $display("FAIL rand_cmd[%0d]: addr=%h wdata=%h want %h %h", k, mem_addr, mem_wdata, ea, ewd);
         end
         n_checks++;
         if ({if_rvalid, d_rvalid} !== {pend_if && !fl, pend_d}) begin
            n_fail++;
            $display("FAIL rand_rvalid[%0d]: if/d=%b want %b", k, {if_rvalid, d_rvalid}, {pend_if && !fl, pend_d});
         end
         if (pend_if && !fl) begin
            n_checks++;
            if (if_rdata !== pend_data) begin
               n_fail++;
               $display("FAIL rand_if_rdata[%0d]: got %h want %h", k, if_rdata, pend_data);
            end
         end
         if (pend_d) begin
            n_checks++;
            if (d_rdata !== pend_data) begin
               n_fail++;
               $display("FAIL rand_d_rdata[%0d]: got %h want %h", k, d_rdata, pend_data);
            end
         end
         pend_if = eif;
         pend_d  = ed && !dw;
         if (eif)             pend_data = ref_rd(ia);
         else if (ed && !dw)  pend_data = ref_rd(da);
         if (ed && dw)        ref_mem[int'(da)] = dd;
         if (ir && !eif && !fl) waited = (waited >= SMAX) ? SMAX : waited + 1;
         else                   waited = 0;
         ir_hold = ir && !eif && !fl;
         dr_hold = dr && !ed;
         @(negedge clk);
      end
      drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 48'h0);
      @(negedge clk);
      test_reset();
      test_fetch_only();
      test_starvation();
      test_write_read();
      test_flush();
      test_flush_vs_starve();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cpu_ad48_mem_arb.md
# cpu_ad48_mem_arb

Two-port arbiter that shares one single-ported, word-addressed 48-bit memory between the cpu_ad48 instruction-fetch stage and the load/store stage. It grants at most one access per cycle, tracks read-response ownership across the memory's fixed one-cycle read latency, and applies an anti-starvation rule so fetch always makes progress. It also drops stale fetch responses on a control-flow redirect (BEQ/BNE/BLT/BLTU/BGE/BGEU taken, JAL, JALR).

## Interface
- AW, 16, word-address width
- DW, 48, data width
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  AW  fetch word address
- if_flush  in  1  redirect: kill in-flight/pending fetch
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DW  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data word address
- d_wdata  in  DW  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data read data valid
- d_rdata  out  DW  data read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en & !mem_we

## Operation
- Grant logic is combinational from requests and registered state. At most one of if_gnt/d_gnt is high per cycle.
- Priority: data wins by default (the older instruction), except when starve_cnt == STARVE_MAX and both request. Then fetch wins.
- starve_cnt (4-bit register): increments when if_req & !if_gnt & !if_flush, saturating at STARVE_MAX. Clears when if_gnt, when !if_req, or when if_flush.
- if_flush high in cycle t:
  - if_gnt forced 0 in t; data may still be granted.
  - A fetch read granted in t-1 gets its if_rvalid in t suppressed.
- Issue: on a grant, mem_en=1 and mem_addr/mem_we/mem_wdata come from the winner in the same cycle. Fetch always has mem_we=0. With no grant, mem_en=0 and the other mem outputs are don't-care (driven 0).
- Ownership register `own` in {NONE, IF, D}:
  - Set to IF on a fetch grant and to D on a data read grant.
  - Set to NONE on a data write or no grant.
  - In cycle t+1: if_rvalid = (own==IF) & !if_flush; d_rvalid = (own==D).
- if_rdata and d_rdata are both wired directly to mem_rdata; they are meaningful only when the matching rvalid is high.
- Writes produce no response.
- Back-to-back grants every cycle are allowed. Accesses reach memory in grant order.

## Timing
- Request-to-grant: 0 cycles when the requester wins.
- Grant-to-rvalid: exactly 1 cycle.
- Throughput: 1 access per cycle.
- Reset (reset=1 at a rising edge):
  - own=NONE, starve_cnt=0.
  - While reset is high: if_gnt=d_gnt=0, mem_en=0, if_rvalid=d_rvalid=0.
  - A read granted in the cycle before reset asserts produces no rvalid.
- Simultaneous if_flush and the fetch starvation threshold: flush wins. No fetch grant, and the counter clears.
- d_we changing while d_req is high and ungranted is a requester protocol violation. The arbiter samples only in the grant cycle.
- STARVE_MAX bounds fetch wait: with both requesting continuously, fetch is granted at least once every STARVE_MAX+1 cycles.

## Structure
- Package cpu_ad48_mem_pkg holds:
  - own_t enum (OWN_NONE, OWN_IF, OWN_D);
  - default AW/DW constants shared with cpu_ad48 memories.
- One sub-module, cpu_ad48_starve_ctr: saturating counter with inc, clr, sat output; parameterised by STARVE_MAX.
- Remainder (grant mux, own register, rvalid decode) lives in the top module.

## Test plan
- Fetch only, addresses 0,1,2 on consecutive cycles: if_gnt each cycle. if_rvalid one cycle later with mem[0..2]. d_rvalid stays 0.
- Both request reads every cycle, STARVE_MAX=4: grant sequence is D,D,D,D,IF repeating. Each rvalid goes to the matching port, and data is never misrouted.
- Data write 0x123456789ABC to addr 5 at t, fetch read addr 5 at t+1: d_gnt at t, no d_rvalid. if_rvalid at t+2 with 0x123456789ABC.
- Fetch granted at t, if_flush at t+1: if_rvalid=0 at t+1 and if_gnt=0 at t+1. A data read requested at t+1 is granted, and d_rvalid is high at t+2.
- reset asserted the cycle after a data read grant: d_rvalid=0. After release, all outputs are 0 until a new request arrives, and starve_cnt restarts from 0.
- if_req held high for 6 cycles with d_req high: fetch is granted no later than the 5th cycle, and the counter never exceeds 4.
